// File: rtl/chip_interface_pkg.sv
// -----------------------------------------------------------------------------
// chip_interface_pkg
//   Shared definitions for the 4-lane nibble link: TX/RX state encodings,
//   the fixed line symbols and the check-nibble rule used by both ends.
// -----------------------------------------------------------------------------
package chip_interface_pkg;

    // Transmitter sequence: one state per symbol, plus an idle gap between frames.
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_LO,
        TX_HI,
        TX_CHK,
        TX_STOP,
        TX_GAP
    } tx_state_t;

    // Receiver sequence: WAIT_IDLE re-synchronises after a bad frame by
    // waiting for the idle level before hunting for the next START.
    typedef enum logic [2:0] {
        RX_WAIT_IDLE,
        RX_IDLE,
        RX_START,
        RX_LO,
        RX_HI,
        RX_CHK,
        RX_STOP
    } rx_state_t;

    localparam logic [3:0] SYM_START = 4'h0;
    localparam logic [3:0] SYM_STOP  = 4'hF;
    localparam logic [3:0] SYM_IDLE  = 4'hF;
    localparam logic [3:0] CHK_KEY   = 4'hA;

    // Check symbol carried in the fourth slot of every frame.
    function automatic logic [3:0] check_nibble(input logic [7:0] data);
        return data[3:0] ^ data[7:4] ^ CHK_KEY;
    endfunction

endpackage

// File: rtl/chip_interface_hex_to_seven_seg.sv
// -----------------------------------------------------------------------------
// hex_to_seven_seg
//   Hexadecimal digit to active-low seven-segment pattern.
//   Ports:
//     value    [3:0] in   digit 0..F
//     segments [6:0] out  active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module hex_to_seven_seg (
    input  logic [3:0] value,
    output logic [6:0] segments
);

    always_comb begin
        // NOTE: assign a default before the case so every path drives the
        // output; a path without an assignment would infer a latch.
        segments = 7'b1111111;
        case (value)
            4'h0: segments = 7'b1000000;
            4'h1: segments = 7'b1111001;
            4'h2: segments = 7'b0100100;
            4'h3: segments = 7'b0110000;
            4'h4: segments = 7'b0011001;
            4'h5: segments = 7'b0010010;
            4'h6: segments = 7'b0000010;
            4'h7: segments = 7'b1111000;
            4'h8: segments = 7'b0000000;
            4'h9: segments = 7'b0010000;
            4'hA: segments = 7'b0001000;
            4'hB: segments = 7'b0000011;
            4'hC: segments = 7'b1000110;
            4'hD: segments = 7'b0100001;
            4'hE: segments = 7'b0000110;
            4'hF: segments = 7'b0001110;
            default: segments = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/chip_interface.sv
// -----------------------------------------------------------------------------
// chip_interface
//   Board-level nibble link. TX sends the switch byte as a 5-symbol frame
//   (START, low nibble, high nibble, CHK, STOP) over four lanes, repeating
//   with a one-symbol gap while enabled. RX synchronises the incoming lanes,
//   samples each symbol mid-period, checks CHK/STOP and reports the byte.
//   Ports:
//     CLOCK_50           in   sole clock, rising edge
//     KEY                in   synchronous active-high reset
//     SW[9:0]            in   [0] tx enable, [8:1] tx byte, [9] unused
//     GPIO_1_D14..D17    out  transmit lanes 0..3
//     GPIO_0_D14..D17    in   receive lanes 0..3 (asynchronous)
//     LEDR[17:0]         out  [7:0] last good byte, [8] rx seen, [9] rx error,
//                             [10] tx busy, [17:11] zero
//     HEX5/HEX4          out  tx byte high/low nibble (active-low segments)
//     HEX1/HEX0          out  last good rx byte high/low nibble
//   CLKS_PER_BIT must be even and at least 4.
// -----------------------------------------------------------------------------
module chip_interface #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic        CLOCK_50,
    input  logic        KEY,
    input  logic [9:0]  SW,
    output logic        GPIO_1_D14,
    output logic        GPIO_1_D15,
    output logic        GPIO_1_D16,
    output logic        GPIO_1_D17,
    input  logic        GPIO_0_D14,
    input  logic        GPIO_0_D15,
    input  logic        GPIO_0_D16,
    input  logic        GPIO_0_D17,
    output logic [17:0] LEDR,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX0
);

    import chip_interface_pkg::*;

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] SYM_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t        tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [7:0]       tx_byte;
    logic [3:0]       tx_lanes;
    logic             tx_busy;

    // Lanes are registered so the symbol changes exactly on the state change.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (KEY) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_byte  <= '0;
            tx_lanes <= SYM_IDLE;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt <= '0;
                    if (SW[0]) begin
                        tx_byte  <= SW[8:1];
                        tx_lanes <= SYM_START;
                        tx_state <= TX_START;
                    end
                end
                default: begin
                    if (tx_cnt != SYM_LAST) begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end else begin
                        tx_cnt <= '0;
                        case (tx_state)
                            TX_START: begin
                                tx_state <= TX_LO;
                                tx_lanes <= tx_byte[3:0];
                            end
                            TX_LO: begin
                                tx_state <= TX_HI;
                                tx_lanes <= tx_byte[7:4];
                            end
                            TX_HI: begin
                                tx_state <= TX_CHK;
                                tx_lanes <= check_nibble(tx_byte);
                            end
                            TX_CHK: begin
                                tx_state <= TX_STOP;
                                tx_lanes <= SYM_STOP;
                            end
                            TX_STOP: begin
                                tx_state <= TX_GAP;
                                tx_lanes <= SYM_IDLE;
                            end
                            TX_GAP: begin
                                // The switch byte is captured only when a frame
                                // begins, so mid-frame edits land in the next one.
                                if (SW[0]) begin
                                    tx_byte  <= SW[8:1];
                                    tx_lanes <= SYM_START;
                                    tx_state <= TX_START;
                                end else begin
                                    tx_lanes <= SYM_IDLE;
                                    tx_state <= TX_IDLE;
                                end
                            end
                            default: begin
                                tx_lanes <= SYM_IDLE;
                                tx_state <= TX_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign tx_busy    = (tx_state != TX_IDLE);
    assign GPIO_1_D14 = tx_lanes[0];
    assign GPIO_1_D15 = tx_lanes[1];
    assign GPIO_1_D16 = tx_lanes[2];
    assign GPIO_1_D17 = tx_lanes[3];

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [3:0]       rx_raw;
    logic [3:0]       rx_meta;
    logic [3:0]       rx_sync;
    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [3:0]       rx_lo;
    logic [3:0]       rx_hi;
    logic [3:0]       rx_chk;
    logic [7:0]       rx_byte;
    logic             rx_seen;
    logic             rx_err;
    logic             data_valid;

    assign rx_raw = {GPIO_0_D17, GPIO_0_D16, GPIO_0_D15, GPIO_0_D14};

    // Two-flop synchroniser; reset to the idle level so a fresh receiver
    // leaves WAIT_IDLE promptly on a quiet line.
    always_ff @(posedge CLOCK_50) begin
        if (KEY) begin
            rx_meta <= SYM_IDLE;
            rx_sync <= SYM_IDLE;
        end else begin
            rx_meta <= rx_raw;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (KEY) begin
            rx_state   <= RX_WAIT_IDLE;
            rx_cnt     <= '0;
            rx_lo      <= '0;
            rx_hi      <= '0;
            rx_chk     <= '0;
            rx_byte    <= '0;
            rx_seen    <= 1'b0;
            rx_err     <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (rx_state)
                RX_WAIT_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_sync == SYM_IDLE) rx_state <= RX_IDLE;
                end
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_sync == SYM_START) rx_state <= RX_START;
                end
                RX_START: begin
                    // START must hold for half a symbol; anything shorter is
                    // treated as a glitch. Reaching the half point also aligns
                    // all later samples to mid-symbol.
                    if (rx_sync != SYM_START) begin
                        rx_state <= RX_IDLE;
                        rx_cnt   <= '0;
                    end else if (rx_cnt == HALF_LAST) begin
                        rx_state <= RX_LO;
                        rx_cnt   <= '0;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (rx_cnt != SYM_LAST) begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end else begin
                        rx_cnt <= '0;
                        case (rx_state)
                            RX_LO: begin
                                rx_lo    <= rx_sync;
                                rx_state <= RX_HI;
                            end
                            RX_HI: begin
                                rx_hi    <= rx_sync;
                                rx_state <= RX_CHK;
                            end
                            RX_CHK: begin
                                rx_chk   <= rx_sync;
                                rx_state <= RX_STOP;
                            end
                            RX_STOP: begin
                                if (rx_sync == SYM_STOP &&
                                    rx_chk == check_nibble({rx_hi, rx_lo})) begin
                                    data_valid <= 1'b1;
                                    rx_byte    <= {rx_hi, rx_lo};
                                    rx_seen    <= 1'b1;
                                    rx_state   <= RX_IDLE;
                                end else begin
                                    rx_err   <= 1'b1;
                                    rx_state <= RX_WAIT_IDLE;
                                end
                            end
                            default: rx_state <= RX_WAIT_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status and displays
    // ------------------------------------------------------------------
    logic unused_sw;
    assign unused_sw = SW[9];

    assign LEDR = {7'b0, tx_busy, rx_err, rx_seen, rx_byte};

    hex_to_seven_seg u_hex5 (.value(tx_byte[7:4]), .segments(HEX5));
    hex_to_seven_seg u_hex4 (.value(tx_byte[3:0]), .segments(HEX4));
    hex_to_seven_seg u_hex1 (.value(rx_byte[7:4]), .segments(HEX1));
    hex_to_seven_seg u_hex0 (.value(rx_byte[3:0]), .segments(HEX0));

endmodule

// File: tb/tb_chip_interface.sv
// -----------------------------------------------------------------------------
// tb_chip_interface
//   Directed sequence with randomized bytes against a frame/status model.
// -----------------------------------------------------------------------------
module tb_chip_interface;

    localparam int CPB          = 8;
    localparam int FRAME_CYCLES = 6 * CPB;
    localparam int DV_LIMIT     = (11 * CPB) / 2 + 4;

    logic        clk = 1'b0;
    logic        key;
    logic [9:0]  sw;
    logic        loop_en;
    logic [3:0]  drv_lanes;
    logic [3:0]  tx_lanes;
    logic [3:0]  rx_lanes;
    logic [17:0] ledr;
    logic [6:0]  hex5, hex4, hex1, hex0;

    always #5 clk = ~clk;

    assign rx_lanes = loop_en ? tx_lanes : drv_lanes;

    chip_interface #(.CLKS_PER_BIT(CPB)) dut (
        .CLOCK_50   (clk),
        .KEY        (key),
        .SW         (sw),
        .GPIO_1_D14 (tx_lanes[0]),
        .GPIO_1_D15 (tx_lanes[1]),
        .GPIO_1_D16 (tx_lanes[2]),
        .GPIO_1_D17 (tx_lanes[3]),
        .GPIO_0_D14 (rx_lanes[0]),
        .GPIO_0_D15 (rx_lanes[1]),
        .GPIO_0_D16 (rx_lanes[2]),
        .GPIO_0_D17 (rx_lanes[3]),
        .LEDR       (ledr),
        .HEX5       (hex5),
        .HEX4       (hex4),
        .HEX1       (hex1),
        .HEX0       (hex0)
    );

    int checks   = 0;
    int failures = 0;

    // Expected receiver status
    logic [7:0] exp_byte;
    logic       exp_seen;
    logic       exp_err;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Standard hex digit patterns, active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_model(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;
            4'h3: return 7'h30;  4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;  4'h8: return 7'h00;
            4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // Frame symbols, slot s at bits [4s+3:4s]: START, lo, hi, CHK, STOP
    function automatic logic [19:0] make_frame(input logic [7:0] b);
        logic [3:0] lo, hi;
        lo = b[3:0];
        hi = b[7:4];
        return {4'hF, lo ^ hi ^ 4'hA, hi, lo, 4'h0};
    endfunction

    task automatic check_status(input string tag);
        check({tag, " ledr_byte"}, ledr[7:0], exp_byte);
        check({tag, " ledr_seen"}, ledr[8], exp_seen);
        check({tag, " ledr_err"}, ledr[9], exp_err);
        check({tag, " ledr_top"}, ledr[17:11], 7'h00);
        check({tag, " hex1"}, hex1, seg_model(exp_byte[7:4]));
        check({tag, " hex0"}, hex0, seg_model(exp_byte[3:0]));
    endtask

    // Call at a negedge before the edge on which TX enters START. Follows one
    // full frame period in loopback; optionally rewrites SW at offset change_at.
    task automatic watch_frame(input logic [7:0] b, input logic [9:0] sw_next,
                               input int change_at, input string tag);
        logic [19:0] f;
        logic [3:0]  sym;
        int          dv;
        f  = make_frame(b);
        dv = 0;
        for (int o = 0; o < FRAME_CYCLES; o++) begin
            @(negedge clk);
            if (o % CPB == CPB / 2) begin
                sym = (o / CPB < 5) ? f[4 * (o / CPB) +: 4] : 4'hF;
                check({tag, " lane"}, tx_lanes, sym);
            end
            if (o == CPB / 2) begin
                check({tag, " hex5"}, hex5, seg_model(b[7:4]));
                check({tag, " hex4"}, hex4, seg_model(b[3:0]));
            end
            if (o == FRAME_CYCLES - 1) check({tag, " busy"}, ledr[10], 1'b1);
            if (dut.data_valid === 1'b1) begin
                dv++;
                check({tag, " dv_latency_ok"}, o <= DV_LIMIT, 1'b1);
                check({tag, " dv_byte"}, ledr[7:0], b);
                check({tag, " dv_seen"}, ledr[8], 1'b1);
            end
            if (o == change_at) sw = sw_next;
        end
        check({tag, " dv_count"}, dv, 1);
        exp_byte = b;
        exp_seen = 1'b1;
        check_status(tag);
    endtask

    // Drives a hand-built frame on the receive lanes, then idle for two symbols.
    task automatic drive_frame(input logic [19:0] f, output int dv);
        dv = 0;
        for (int s = 0; s < 6; s++) begin
            drv_lanes = (s < 5) ? f[4 * s +: 4] : 4'hF;
            repeat ((s < 5) ? CPB : 2 * CPB) begin
                @(negedge clk);
                if (dut.data_valid === 1'b1) dv++;
            end
        end
    endtask

    initial begin
        logic [7:0]  prev, nb, gb, kb;
        logic [19:0] f;
        int          dv, bad_lane, bad_dv, bad_busy;

        key       = 1'b1;
        sw        = 10'h000;
        loop_en   = 1'b1;
        drv_lanes = 4'hF;
        exp_byte  = 8'h00;
        exp_seen  = 1'b0;
        exp_err   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset lanes", tx_lanes, 4'hF);
        check("reset ledr", ledr, 18'h0);
        check("reset dv", dut.data_valid, 1'b0);
        check("reset hex5", hex5, seg_model(4'h0));
        check("reset hex4", hex4, seg_model(4'h0));
        check_status("reset");

        // Disabled transmitter stays quiet
        key = 1'b0;
        bad_lane = 0; bad_dv = 0; bad_busy = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx_lanes !== 4'hF) bad_lane++;
            if (dut.data_valid !== 1'b0) bad_dv++;
            if (ledr[10] !== 1'b0) bad_busy++;
        end
        check("idle lane_changes", bad_lane, 0);
        check("idle dv_pulses", bad_dv, 0);
        check("idle busy_cycles", bad_busy, 0);

        // Reset pulse with enable set: byte 00, then A5 written mid-frame
        key = 1'b1;
        sw  = 10'h001;
        repeat (2) @(negedge clk);
        key = 1'b0;
        watch_frame(8'h00, {1'b0, 8'hA5, 1'b1}, 20, "first");
        watch_frame(8'hA5, {1'b0, 8'hA5, 1'b1}, -1, "a5");
        check("a5 hex1_literal", hex1, 7'b0001000);
        check("a5 hex0_literal", hex0, 7'b0010010);

        // Random bytes written at random points in the preceding frame
        prev = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            nb = 8'($urandom);
            watch_frame(prev, {1'b0, nb, 1'b1}, $urandom_range(1, FRAME_CYCLES - 2), "rand");
            prev = nb;
        end

        // Enable drops mid-frame: frame completes, then TX idles
        watch_frame(prev, {1'b0, prev, 1'b0}, 2 * CPB + 1, "disable");
        bad_lane = 0; bad_busy = 0;
        repeat (3 * CPB) begin
            @(negedge clk);
            if (tx_lanes !== 4'hF) bad_lane++;
            if (ledr[10] !== 1'b0) bad_busy++;
        end
        check("disable lane_changes", bad_lane, 0);
        check("disable busy_cycles", bad_busy, 0);

        // Hand-driven receive lanes
        loop_en = 1'b0;
        repeat (CPB) @(negedge clk);

        // Short START glitch is ignored
        drv_lanes = 4'h0;
        repeat (2) @(negedge clk);
        drv_lanes = 4'hF;
        dv = 0;
        repeat (2 * CPB) begin
            @(negedge clk);
            if (dut.data_valid === 1'b1) dv++;
        end
        check("glitch dv_count", dv, 0);
        check_status("glitch");

        // Bad STOP symbol
        f = make_frame(8'($urandom));
        f[19:16] = 4'($urandom_range(0, 14));
        drive_frame(f, dv);
        exp_err = 1'b1;
        check("badstop dv_count", dv, 0);
        check_status("badstop");

        // Reset clears the sticky status
        key = 1'b1;
        repeat (2) @(negedge clk);
        key = 1'b0;
        @(negedge clk);
        exp_byte = 8'h00; exp_seen = 1'b0; exp_err = 1'b0;
        check("clear ledr", ledr, 18'h0);
        check("clear hex5", hex5, seg_model(4'h0));
        check_status("clear");

        // Good hand-driven frame
        gb = 8'($urandom);
        drive_frame(make_frame(gb), dv);
        check("good1 dv_count", dv, 1);
        exp_byte = gb; exp_seen = 1'b1;
        check_status("good1");

        // Byte 12 with CHK forced to 0
        f = make_frame(8'h12);
        f[15:12] = 4'h0;
        drive_frame(f, dv);
        exp_err = 1'b1;
        check("badchk dv_count", dv, 0);
        check_status("badchk");

        // Receiver recovers after an error; error flag stays set
        gb = 8'($urandom);
        drive_frame(make_frame(gb), dv);
        check("good2 dv_count", dv, 1);
        exp_byte = gb; exp_seen = 1'b1;
        check_status("good2");

        // Reset asserted during the HI symbol of a loopback frame
        loop_en = 1'b1;
        kb = 8'($urandom);
        sw = {1'b0, kb, 1'b1};
        for (int o = 0; o <= 2 * CPB + 2; o++) @(negedge clk);
        key = 1'b1;
        @(negedge clk);
        check("midreset lanes", tx_lanes, 4'hF);
        check("midreset dv", dut.data_valid, 1'b0);
        check("midreset ledr", ledr, 18'h0);
        check("midreset hex5", hex5, seg_model(4'h0));
        exp_byte = 8'h00; exp_seen = 1'b0; exp_err = 1'b0;
        key = 1'b0;
        watch_frame(kb, {1'b0, kb, 1'b0}, FRAME_CYCLES - 4, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chip_interface.md
CHIP_INTERFACE -- requirements
Module: chip_interface

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, clock cycles per transmitted symbol; must be even and at least 4.
REQ-002 SHALL have port CLOCK_50, input, 1, sole clock, rising edge.
REQ-003 SHALL have port KEY, input, 1, reset: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port SW, input, 10, controls: SW[0]=tx enable, SW[8:1]=tx byte, SW[9] ignored.
REQ-005 SHALL have ports GPIO_1_D14..D17, output, 1 each, transmit lanes 0..3.
REQ-006 SHALL have ports GPIO_0_D14..D17, input, 1 each, receive lanes 0..3, asynchronous.
REQ-007 SHALL have port LEDR, output, 18, status: [7:0] last good rx byte, [8] rx-seen sticky, [9] rx-error sticky, [10] tx busy, [17:11]=0.
REQ-008 SHALL have ports HEX5, HEX4, HEX1, HEX0, output, 7 each, active-low segments {g,f,e,d,c,b,a}: HEX5/HEX4 = tx byte high/low nibble; HEX1/HEX0 = LEDR[7:4]/[3:0].
REQ-009 SHALL contain an internal 1-bit signal named data_valid, visible hierarchically.

Function
REQ-010 Frame SHALL be 5 symbols on lanes[3:0], each CLKS_PER_BIT cycles: START 4'h0, byte[3:0], byte[7:4], CHK = byte[3:0]^byte[7:4]^4'hA, STOP 4'hF.
REQ-011 Idle lane level SHALL be 4'hF.
REQ-012 TX FSM states SHALL be IDLE, START, LO, HI, CHK, STOP, GAP; GAP holds 4'hF one symbol period.
REQ-013 In IDLE with SW[0]=1, TX SHALL latch SW[8:1] and enter START next cycle; frames repeat back-to-back via GAP (period 6*CLKS_PER_BIT).
REQ-014 TX byte SHALL be latched at START only; SW changes mid-frame affect the next frame.
REQ-015 SW[0] falling mid-frame SHALL let the current frame finish, then TX stays in IDLE.
REQ-016 LEDR[10] SHALL be 1 in every TX state except IDLE.
REQ-017 RX SHALL pass lanes through a 2-flop synchronizer before any use.
REQ-018 RX FSM states SHALL be WAIT_IDLE, IDLE, START, LO, HI, CHK, STOP; WAIT_IDLE waits for synced lanes == 4'hF.
REQ-019 In IDLE, synced lanes == 4'h0 SHALL start a counter; if still 4'h0 at CLKS_PER_BIT/2 cycles, enter LO; otherwise return to IDLE (glitch reject).
REQ-020 RX SHALL sample each later symbol once, CLKS_PER_BIT cycles after the prior sample (mid-symbol).
REQ-021 After STOP sample: if STOP==4'hF and CHK matches, data_valid SHALL pulse high exactly one cycle, LEDR[7:0] update, and LEDR[8] set, all in the same cycle.
REQ-022 On STOP or CHK mismatch, SHALL assert no data_valid, leave LEDR[7:0] unchanged, set LEDR[9], and enter WAIT_IDLE.
REQ-023 After a good frame, RX SHALL return to IDLE.
REQ-024 With GPIO_1 looped to GPIO_0, first data_valid SHALL occur within 5.5*CLKS_PER_BIT+4 cycles after TX enters START.
REQ-025 7-seg decode SHALL be standard hex 0-F, active-low: e.g. 0=7'b1000000, 5=7'b0010010, A=7'b0001000.

Reset
REQ-026 While KEY=1 at a clock edge: TX->IDLE, RX->WAIT_IDLE, transmit lanes 4'hF, data_valid 0, LEDR 0, tx byte register 0, counters 0.
REQ-027 Reset mid-frame SHALL abort the frame; lanes SHALL be 4'hF from the next edge.
REQ-028 With SW[0]=1, TX SHALL enter START on the first edge after KEY deasserts.
REQ-029 HEX outputs SHALL follow the reset register values; HEX0/HEX1 show "0".

Structure
REQ-030 A shared package SHALL hold TX/RX state enums, START/STOP/IDLE symbol and CHK_KEY 4'hA constants, and the check-nibble function.
REQ-031 One sub-module, hex_to_seven_seg (4-bit in, 7-bit active-low out), SHALL be instantiated four times; TX and RX FSMs stay in the top.

Verification
REQ-032 Loopback, SW=10'h001, reset pulse: data_valid within 48 cycles of reset release -> LEDR[7:0]=8'h00, LEDR[8]=1, HEX0=HEX1=7'b1000000.
REQ-033 Loopback, SW[8:1]=8'hA5, SW[0]=1: LEDR[7:0]=8'hA5; HEX1=7'b0001000, HEX0=7'b0010010; frames repeat every 48 cycles.
REQ-034 Receive lanes driven with a frame with CHK=4'h0 for byte 8'h12: no data_valid, LEDR[9]=1, LEDR[7:0] unchanged.
REQ-035 SW[0]=0 for 200 cycles: GPIO_1 lanes constant 4'hF, data_valid never high, LEDR[10]=0.
REQ-036 KEY asserted during HI symbol: lanes 4'hF next cycle; after release, a clean frame and one data_valid pulse follow.
